mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 37 +++
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_access_unit_data_mem_sync.sv | 25 ++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: operation/select encodings,
// FSM state type and default geometry.
package mem_access_unit_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RMW   = 2'd3
  } mem_op_e;

  // Write-data source select.
  typedef enum logic [1:0] {
    SRC_ACC  = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_SAVE = 2'd2,
    SRC_ZERO = 2'd3
  } mem_src_e;

  // Address source select.
  typedef enum logic [1:0] {
    ADR_HEAD  = 2'd0,
    ADR_STACK = 2'd1,
    ADR_CACHE = 2'd2,
    ADR_ALU   = 2'd3
  } mem_addr_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between a requester and the memory access unit.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; all request fields are sampled on that edge only.
// resp_valid is a one-cycle pulse with no back-pressure; mem_out and oob_err
// are meaningful while it is high, and oob_err is low whenever it is low.
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  mem_op_e           mem_op;
  mem_src_e          mem_src;
  mem_addr_e         mem_addr;
  logic [DATA_W-1:0] acc_out;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] save_out;
  logic [DATA_W-1:0] head_out;
  logic [DATA_W-1:0] stack_out;
  logic [DATA_W-1:0] cache_out;
  logic [DATA_W-1:0] delta;
  logic              resp_valid;
  logic [DATA_W-1:0] mem_out;
  logic              oob_err;

  modport master (
    output req_valid, mem_op, mem_src, mem_addr,
    output acc_out, alu_out, save_out, head_out, stack_out, cache_out, delta,
    input  req_ready, resp_valid, mem_out, oob_err
  );

  modport slave (
    input  req_valid, mem_op, mem_src, mem_addr,
    input  acc_out, alu_out, save_out, head_out, stack_out, cache_out, delta,
    output req_ready, resp_valid, mem_out, oob_err
  );

endinterface

// File: rtl/mem_access_unit_data_mem_sync.sv
// Single-port-style word store: synchronous write, registered read with read
// enable so the read register holds between accesses. No reset on contents.
module data_mem_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on we, capture read word on re; callers keep addresses in range.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: selects address/data sources, runs READ/WRITE/RMW
// against data_mem_sync and returns a one-cycle response pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  output mau_state_e       dbg_state
);

  mau_state_e        state;
  logic              accept;
  logic [DATA_W-1:0] wdata_sel;
  logic [DATA_W-1:0] addr_bus;
  logic [ADDR_W-1:0] addr_sel;
  logic              oob_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] delta_q;
  logic              rmw_oob_q;
  logic              resp_valid_q;
  logic              oob_q;
  logic              resp_from_mem_q;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] sum;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign accept = bus.req_valid && (state == ST_IDLE);

  // Write-data source mux.
  always_comb begin
    wdata_sel = '0;
    case (bus.mem_src)
      SRC_ACC:  wdata_sel = bus.acc_out;
      SRC_ALU:  wdata_sel = bus.alu_out;
      SRC_SAVE: wdata_sel = bus.save_out;
      default:  wdata_sel = '0;
    endcase
  end

  // Address source mux.
  always_comb begin
    addr_bus = '0;
    case (bus.mem_addr)
      ADR_HEAD:  addr_bus = bus.head_out;
      ADR_STACK: addr_bus = bus.stack_out;
      ADR_CACHE: addr_bus = bus.cache_out;
      default:   addr_bus = bus.alu_out;
    endcase
  end

  // Size cast truncates to the low bits or zero-extends as needed.
  assign addr_sel = ADDR_W'(addr_bus);
  assign oob_sel  = ({1'b0, addr_sel} >= (ADDR_W + 1)'(DEPTH));
  assign sum      = rd_data + delta_q;

  // Memory write port: plain WRITE at accept, RMW write-back in RMW_WR.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_sel;
    mem_wdata = wdata_sel;
    if (state == ST_RMW_WR) begin
      mem_we    = !rmw_oob_q;
      mem_waddr = addr_q;
      mem_wdata = sum;
    end else if (accept && (bus.mem_op == OP_WRITE)) begin
      mem_we = !oob_sel;
    end
  end

  assign mem_re = accept && !oob_sel &&
                  ((bus.mem_op == OP_READ) || (bus.mem_op == OP_RMW));

  data_mem_sync #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (addr_sel),
    .rdata (rd_data)
  );

  // Control FSM and registered response; out_q keeps mem_out stable between
  // pulses and absorbs the read word after a READ pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      resp_valid_q    <= 1'b0;
      oob_q           <= 1'b0;
      resp_from_mem_q <= 1'b0;
      out_q           <= '0;
      addr_q          <= '0;
      delta_q         <= '0;
      rmw_oob_q       <= 1'b0;
    end else begin
      resp_valid_q    <= 1'b0;
      oob_q           <= 1'b0;
      resp_from_mem_q <= 1'b0;
      if (resp_valid_q && resp_from_mem_q) out_q <= rd_data;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (bus.mem_op)
              OP_READ: begin
                resp_valid_q    <= 1'b1;
                oob_q           <= oob_sel;
                resp_from_mem_q <= !oob_sel;
                if (oob_sel) out_q <= '0;
              end
              OP_WRITE: begin
                resp_valid_q <= 1'b1;
                oob_q        <= oob_sel;
                out_q        <= wdata_sel;
              end
              OP_RMW: begin
                state     <= ST_RMW_WR;
                addr_q    <= addr_sel;
                delta_q   <= bus.delta;
                rmw_oob_q <= oob_sel;
              end
              default: ;
            endcase
          end
        end
        ST_RMW_WR: begin
          state        <= ST_IDLE;
          resp_valid_q <= 1'b1;
          oob_q        <= rmw_oob_q;
          out_q        <= rmw_oob_q ? '0 : sum;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.oob_err    = oob_q;
  assign bus.mem_out    = (resp_valid_q && resp_from_mem_q) ? rd_data : out_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with DEPTH=200 so both in-range
// and out-of-range addresses are reachable with 8-bit buses.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int DEP = 200;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  mau_state_e dbg_state;
  int         cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if #(.DATA_W(DW)) bus ();

  mem_access_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [DW-1:0]   exp_q[$];
  bit              exp_oob_q[$];
  bit              exp_chk_q[$];
  int              exp_cyc_q[$];
  string           exp_tag_q[$];
  logic [DW-1:0]   model_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input bit oob, input bit chk,
                          input int c, input string tag);
    exp_q.push_back(d);
    exp_oob_q.push_back(oob);
    exp_chk_q.push_back(chk);
    exp_cyc_q.push_back(c);
    exp_tag_q.push_back(tag);
  endtask

  // ---------------- driver ----------------
  task automatic scramble();
    bus.acc_out   = DW'($urandom);
    bus.alu_out   = DW'($urandom);
    bus.save_out  = DW'($urandom);
    bus.head_out  = DW'($urandom);
    bus.stack_out = DW'($urandom);
    bus.cache_out = DW'($urandom);
    bus.delta     = DW'($urandom);
    bus.mem_op    = mem_op_e'($urandom_range(0, 3));
    bus.mem_src   = mem_src_e'($urandom_range(0, 3));
    bus.mem_addr  = mem_addr_e'($urandom_range(0, 3));
  endtask

  // Presents one request, waits for acceptance, updates the reference model
  // (when want is set) and scrambles the inputs right after the accept edge.
  task automatic send(input mem_op_e op, input mem_src_e src, input mem_addr_e asel,
                      input logic [DW-1:0] aval, input logic [DW-1:0] dval,
                      input logic [DW-1:0] dl, input bit want, input string tag,
                      output int acc);
    logic [DW-1:0] b [6];
    logic [DW-1:0] wd;
    logic [DW-1:0] a;
    bit            oob;
    int            idx_a;
    int            w;
    @(negedge clk);
    for (int i = 0; i < 6; i++) b[i] = DW'($urandom);
    idx_a = (asel == ADR_HEAD) ? 3 : (asel == ADR_STACK) ? 4 : (asel == ADR_CACHE) ? 5 : 1;
    b[idx_a] = aval;
    if (src != SRC_ZERO && int'(src) != idx_a) b[int'(src)] = dval;
    wd = (src == SRC_ZERO) ? '0 : b[int'(src)];
    a  = b[idx_a];
    bus.acc_out   = b[0];
    bus.alu_out   = b[1];
    bus.save_out  = b[2];
    bus.head_out  = b[3];
    bus.stack_out = b[4];
    bus.cache_out = b[5];
    bus.delta     = dl;
    bus.mem_op    = op;
    bus.mem_src   = src;
    bus.mem_addr  = asel;
    bus.req_valid = 1'b1;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (w == 8) begin
      check({tag, "_ready_timeout"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    oob = (int'(a) >= DEP);
    if (want) begin
      case (op)
        OP_READ:  push_exp(oob ? '0 : model_mem[a], oob, 1'b1, acc + 1, tag);
        OP_WRITE: begin
          if (!oob) model_mem[a] = wd;
          push_exp(wd, oob, !oob, acc + 1, tag);
        end
        OP_RMW: begin
          if (!oob) model_mem[a] = model_mem[a] + dl;
          push_exp(oob ? '0 : model_mem[a], oob, 1'b1, acc + 2, tag);
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble();
  endtask

  // ---------------- response monitor ----------------
  logic [DW-1:0] last_out = '0;
  bit            hold_ok  = 1'b1;

  initial begin
    logic [DW-1:0] d;
    bit            o;
    bit            k;
    int            c;
    string         t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_out", 32'(bus.mem_out), 32'd0);
        last_out = '0;
        hold_ok  = 1'b1;
      end else if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
        end else begin
          d = exp_q.pop_front();
          o = exp_oob_q.pop_front();
          k = exp_chk_q.pop_front();
          c = exp_cyc_q.pop_front();
          t = exp_tag_q.pop_front();
          check({t, "_cycle"}, 32'(cyc), 32'(c));
          check({t, "_oob"}, 32'(bus.oob_err), 32'(o));
          if (k) check({t, "_data"}, 32'(bus.mem_out), 32'(d));
          last_out = d;
          hold_ok  = k;
        end
      end else begin
        check("oob_idle", 32'(bus.oob_err), 32'd0);
        if (hold_ok) check("mem_out_hold", 32'(bus.mem_out), 32'(last_out));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a1;
    int a2;
    int a3;
    bus.req_valid = 1'b0;
    scramble();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_resp", 32'(bus.resp_valid), 32'd0);
    check("rst_oob", 32'(bus.oob_err), 32'd0);
    check("rst_out", 32'(bus.mem_out), 32'd0);

    // Give every in-range cell a known value.
    for (int i = 0; i < DEP; i++)
      send(OP_WRITE, SRC_ACC, ADR_HEAD, DW'(i), DW'($urandom), '0, 1'b1, "fill", a1);

    // WRITE then READ on consecutive cycles.
    send(OP_WRITE, SRC_ACC, ADR_HEAD, 8'h10, 8'h5A, '0, 1'b1, "wr_10", a1);
    send(OP_READ,  SRC_ACC, ADR_HEAD, 8'h10, '0, '0, 1'b1, "rd_10", a2);
    check("wr_rd_b2b", 32'(a2 - a1), 32'd1);

    // RMW wrap 0xFF + 1.
    send(OP_WRITE, SRC_ALU, ADR_STACK, 8'h20, 8'hFF, '0, 1'b1, "wr_20ff", a1);
    send(OP_RMW,   SRC_ACC, ADR_CACHE, 8'h20, '0, 8'h01, 1'b1, "rmw_wrap", a1);
    check("rmw_busy_ready", 32'(bus.req_ready), 32'd0);
    check("rmw_busy_state", 32'(dbg_state), 32'(ST_RMW_WR));
    send(OP_READ,  SRC_ACC, ADR_HEAD, 8'h20, '0, '0, 1'b1, "rd_20_wrap", a2);
    check("rmw_gap", 32'(a2 - a1), 32'd2);

    // RMW 0x00 + 0xFF, then RMW and READ back-to-back.
    send(OP_WRITE, SRC_SAVE, ADR_HEAD, 8'h20, 8'h00, '0, 1'b1, "wr_2000", a1);
    send(OP_RMW,   SRC_ACC, ADR_HEAD, 8'h20, '0, 8'hFF, 1'b1, "rmw_neg", a1);
    send(OP_RMW,   SRC_ACC, ADR_ALU,  8'h20, '0, 8'h03, 1'b1, "rmw_neg2", a2);
    send(OP_READ,  SRC_ACC, ADR_HEAD, 8'h20, '0, '0, 1'b1, "rd_20_neg", a3);
    check("rmw_rmw_gap", 32'(a2 - a1), 32'd2);
    check("rmw_rd_gap", 32'(a3 - a2), 32'd2);

    // Out-of-range WRITE/READ at 0xC8, and a possible alias cell.
    send(OP_WRITE, SRC_ACC, ADR_ALU,  8'hC8, 8'hAA, '0, 1'b1, "wr_oob", a1);
    send(OP_READ,  SRC_ACC, ADR_HEAD, 8'hC8, '0, '0, 1'b1, "rd_oob", a2);
    send(OP_RMW,   SRC_ACC, ADR_HEAD, 8'hFF, '0, 8'h11, 1'b1, "rmw_oob", a2);
    send(OP_READ,  SRC_ACC, ADR_HEAD, 8'h48, '0, '0, 1'b1, "rd_alias", a2);

    // Reset while in RMW_WR aborts the write-back and the response.
    send(OP_WRITE, SRC_ACC, ADR_HEAD, 8'h30, 8'h07, '0, 1'b1, "wr_30", a1);
    repeat (2) @(negedge clk);
    send(OP_RMW,   SRC_ACC, ADR_HEAD, 8'h30, '0, DW'($urandom_range(1, 255)), 1'b0, "rmw_abort", a1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_resp", 32'(bus.resp_valid), 32'd0);
    check("abort_out", 32'(bus.mem_out), 32'd0);
    check("abort_oob", 32'(bus.oob_err), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    send(OP_READ,  SRC_ACC, ADR_HEAD, 8'h30, '0, '0, 1'b1, "rd_30_abort", a1);

    // Constant-zero source and NOP.
    send(OP_WRITE, SRC_ZERO, ADR_STACK, 8'h33, 8'hEE, '0, 1'b1, "wr_zero", a1);
    send(OP_NOP,   SRC_ACC, ADR_HEAD, 8'h33, 8'h99, '0, 1'b1, "nop", a1);
    @(negedge clk);
    check("nop_ready", 32'(bus.req_ready), 32'd1);
    check("nop_resp", 32'(bus.resp_valid), 32'd0);
    send(OP_READ,  SRC_ACC, ADR_HEAD, 8'h33, '0, '0, 1'b1, "rd_33", a1);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      send(mem_op_e'($urandom_range(0, 3)), mem_src_e'($urandom_range(0, 3)),
           mem_addr_e'($urandom_range(0, 3)), DW'($urandom_range(0, 255)),
           DW'($urandom), DW'($urandom), 1'b1, "rnd", a1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
